pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Owns the program counter and consumes the branch decision `NextPCSrc` together with the computed target `ALURes`.
- Sequences instruction fetch over a req/rvalid handshake to instruction memory.
- Holds the fetched instruction stable until the core commits it.
- Raises a sticky trap on a misaligned next PC and keeps a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset and used for the first fetch.
- IMEM_TIMEOUT, 255, cycles allowed between `imem_req` assertion and `imem_rvalid` before a fetch-timeout trap.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- NextPCSrc  in  1  1 = take `ALURes` as next PC, 0 = PC+4
- ALURes  in  32  branch/jump target from the ALU
- advance  in  1  core commits the current instruction this cycle
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address, equals pc
- imem_rvalid  in  1  instruction word valid this cycle
- imem_rdata  in  32  instruction word
- instr  out  32  latched instruction
- instr_valid  out  1  `instr` is valid for the current pc
- pc  out  32  current program counter
- pc_plus4  out  32  pc+4, mod 2^32
- trap  out  1  sticky trap flag
- trap_cause  out  2  01 = misaligned target, 10 = fetch timeout
- trap_addr  out  32  offending next-PC (misaligned) or pc (timeout)
- instret  out  64  committed-instruction count

Behaviour:
- Reset: when rst=1 at a rising edge, the following register values apply from the next cycle.
  - state=S_IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP).
  - instr_valid=0, imem_req=0, trap=0, trap_cause=0, trap_addr=0, instret=0, timeout counter=0.
  - Reset asserted mid-fetch or mid-hold aborts immediately; no partial state survives.
- States: S_IDLE, S_FETCH, S_HOLD, S_TRAP.
- S_IDLE:
  - Lasts exactly one cycle after reset is released.
  - Goes to S_FETCH.
- S_FETCH:
  - imem_req=1 and imem_addr=pc, both stable until rvalid.
  - On imem_rvalid=1: instr<=imem_rdata, instr_valid<=1, next state S_HOLD, imem_req drops the following cycle.
  - Minimum fetch latency: one cycle from req to instr_valid, given rvalid in the first S_FETCH cycle.
  - Timeout counter increments each S_FETCH cycle without rvalid. On reaching IMEM_TIMEOUT: trap<=1, trap_cause<=10, trap_addr<=pc, go to S_TRAP.
- S_HOLD:
  - instr, pc and instr_valid are held stable.
  - On advance=1, compute next = NextPCSrc ? {ALURes[31:1],1'b0} : pc+4.
  - If next[1]=1: trap<=1, trap_cause<=01, trap_addr<=next, instr_valid<=0, pc unchanged, instret unchanged, go to S_TRAP.
  - Otherwise: pc<=next, instr_valid<=0, instret<=instret+1, go to S_FETCH, clear timeout counter.
- S_TRAP:
  - Absorbing until rst.
  - imem_req=0, instr_valid=0; advance and rvalid are ignored.
- Ignored inputs:
  - imem_rvalid outside S_FETCH, including a late response after reset, is ignored.
  - advance outside S_HOLD is ignored.
  - NextPCSrc and ALURes are sampled only on the advance cycle in S_HOLD.
- Arithmetic:
  - pc+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000, with no trap.
  - instret wraps at 2^64 silently.
  - The target LSB is cleared per JALR semantics; only bit 1 is checked for misalignment.
- pc_plus4 is combinational from pc and valid in every state.

Decomposition:
- riscv_pkg holds:
  - enum fetch_state_t {S_IDLE, S_FETCH, S_HOLD, S_TRAP}
  - TRAP_MISALIGN=2'b01, TRAP_TIMEOUT=2'b10
  - NOP_INSTR=32'h0000_0013
- No sub-module is required. Next-PC selection and trap check are an inline combinational block; the FSM, pc, instr, counter and trap registers sit in one sequential block.

Test Plan:
- Reset then rvalid with rdata=32'h00500093 in the first S_FETCH cycle:
  - Required: imem_addr=0x0, instr=0x00500093, instr_valid=1 two cycles after rst release.
  - After advance with NextPCSrc=0: pc=0x4, instret=1.
- In S_HOLD at pc=0x10, NextPCSrc=1, ALURes=0x0000_0101, advance=1:
  - Required: pc=0x100 (LSB cleared), no trap, next imem_addr=0x100.
- NextPCSrc=1, ALURes=0x0000_0206, advance=1:
  - Required: trap=1, trap_cause=01, trap_addr=0x206, pc unchanged, instret unchanged, imem_req=0 thereafter, advance ignored.
- pc=0xFFFF_FFFC, NextPCSrc=0, advance=1:
  - Required: pc=0x0000_0000, fetch issued at 0x0, no trap.
- Hold rvalid low for 3 cycles, then rvalid=1:
  - Required: imem_req and imem_addr stable for all 4 cycles, instr latched on the 4th.
  - rvalid pulsed in S_HOLD does not change instr.
- Assert rst during S_FETCH with rvalid arriving in the same cycle:
  - Required: instr_valid=0, pc=RESET_PC, instret=0, trap=0 next cycle.
- Separately, never assert rvalid:
  - Required: trap_cause=10 and trap_addr=pc after IMEM_TIMEOUT cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch path.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_TRAP  = 2'd3
  } fetch_state_t;

  localparam logic [1:0]  TRAP_MISALIGN = 2'b01;
  localparam logic [1:0]  TRAP_TIMEOUT  = 2'b10;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_unit.sv
// Program counter owner and fetch sequencer: one outstanding imem request,
// holds the fetched word until committed, sticky trap on misalignment or timeout.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NextPCSrc,
  input  logic [31:0] ALURes,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_addr,
  output logic [63:0] instret
);

  localparam int TW = $clog2(IMEM_TIMEOUT + 1);

  fetch_state_t  state, state_next;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   next_pc;
  logic          misalign;
  logic          tmo_hit;

  assign pc_plus4  = pc + 32'd4;
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;

  // JALR semantics: bit 0 of the target is dropped, only bit 1 can misalign.
  always_comb begin
    next_pc  = NextPCSrc ? {ALURes[31:1], 1'b0} : pc_plus4;
    misalign = next_pc[1];
    tmo_hit  = (tmo_cnt == TW'(IMEM_TIMEOUT - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: begin
        if (imem_rvalid)  state_next = S_HOLD;
        else if (tmo_hit) state_next = S_TRAP;
      end
      S_HOLD: begin
        if (advance) state_next = misalign ? S_TRAP : S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      trap        <= 1'b0;
      trap_cause  <= 2'b00;
      trap_addr   <= 32'h0;
      instret     <= 64'h0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
          end else if (tmo_hit) begin
            trap       <= 1'b1;
            trap_cause <= TRAP_TIMEOUT;
            trap_addr  <= pc;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (advance) begin
            instr_valid <= 1'b0;
            if (misalign) begin
              trap       <= 1'b1;
              trap_cause <= TRAP_MISALIGN;
              trap_addr  <= next_pc;
            end else begin
              pc      <= next_pc;
              instret <= instret + 64'd1;
              tmo_cnt <= '0;
            end
          end
        end
        S_TRAP:  instr_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; expected values are hand-computed.
module tb_pc_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        NextPCSrc;
  logic [31:0] ALURes;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] trap_addr;
  logic [63:0] instret;

  int tests = 0;
  int fails = 0;

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc), .ALURes(ALURes),
    .advance(advance), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .trap(trap),
    .trap_cause(trap_cause), .trap_addr(trap_addr), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From S_FETCH: return the word, then commit it with the given branch choice.
  task automatic fetch_commit(input logic [31:0] word, input logic src, input logic [31:0] tgt);
    imem_rvalid = 1'b1; imem_rdata = word;
    tick();
    imem_rvalid = 1'b0;
    NextPCSrc = src; ALURes = tgt; advance = 1'b1;
    tick();
    advance = 1'b0; NextPCSrc = 1'b0; ALURes = 32'h0;
  endtask

  initial begin
    rst = 1'b1; NextPCSrc = 1'b0; ALURes = 32'h0; advance = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    check("rst_valid", instr_valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h13);
    check("rst_trap", {trap, trap_cause, trap_addr}, 0);
    check("rst_instret", instret, 0);

    rst = 1'b0;
    tick();
    check("fetch0_req", imem_req, 1);
    check("fetch0_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    check("first_instr", instr, 32'h0050_0093);
    check("first_valid", instr_valid, 1);
    check("hold_req_low", imem_req, 0);

    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("hold_rvalid_ign", instr, 32'h0050_0093);

    advance = 1'b1;
    tick();
    advance = 1'b0;
    check("adv_pc", pc, 32'h4);
    check("adv_instret", instret, 1);
    check("adv_valid_clr", instr_valid, 0);

    for (int i = 0; i < 3; i++) fetch_commit(32'h13, 1'b0, 32'h0);
    check("pc_0x10", pc, 32'h10);

    fetch_commit(32'h13, 1'b1, 32'h0000_0101);
    check("jalr_pc", pc, 32'h100);
    check("jalr_no_trap", trap, 0);
    check("jalr_addr", imem_addr, 32'h100);
    check("jalr_instret", instret, 5);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, 32'h100);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    check("wait_instr", instr, 32'h1234_5678);
    check("wait_valid", instr_valid, 1);

    NextPCSrc = 1'b1; ALURes = 32'h0000_0206; advance = 1'b1;
    tick();
    check("mis_trap", trap, 1);
    check("mis_cause", trap_cause, TRAP_MISALIGN);
    check("mis_addr", trap_addr, 32'h206);
    check("mis_pc", pc, 32'h100);
    check("mis_instret", instret, 5);
    check("mis_valid", instr_valid, 0);
    NextPCSrc = 1'b0; ALURes = 32'h0; imem_rvalid = 1'b1;
    tick(); tick();
    advance = 1'b0; imem_rvalid = 1'b0;
    check("trap_req", imem_req, 0);
    check("trap_pc", pc, 32'h100);
    check("trap_instret", instret, 5);
    check("trap_valid", instr_valid, 0);

    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    fetch_commit(32'h13, 1'b1, 32'hFFFF_FFFC);
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_plus4", pc_plus4, 32'h0);
    fetch_commit(32'h13, 1'b0, 32'h0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_req", imem_req, 1);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_trap", trap, 0);
    check("wrap_instret", instret, 2);

    rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    check("midrst_valid", instr_valid, 0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_instret", instret, 0);
    check("midrst_trap", trap, 0);
    check("midrst_instr", instr, 32'h13);
    rst = 1'b0;
    tick();
    imem_rvalid = 1'b0;
    check("late_rvalid_ign", instr_valid, 0);
    check("late_instr", instr, 32'h13);

    for (int i = 0; i < 254; i++) tick();
    check("tmo_not_yet", trap, 0);
    check("tmo_req_still", imem_req, 1);
    tick();
    check("tmo_trap", trap, 1);
    check("tmo_cause", trap_cause, TRAP_TIMEOUT);
    check("tmo_addr", trap_addr, 32'h0);
    check("tmo_req", imem_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
